// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external combinational ALU
// between two requesters. The winner's operands are latched into registers
// that drive the ALU. The captured result is returned on a single response
// channel, tagged with the id of the requester that owns it.
module alu_share_arbiter #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid0,
  output logic         req_ready0,
  input  logic [n-1:0] req_a0,
  input  logic [n-1:0] req_b0,
  input  logic [3:0]   req_sel0,
  input  logic         req_valid1,
  output logic         req_ready1,
  input  logic [n-1:0] req_a1,
  input  logic [n-1:0] req_b1,
  input  logic [3:0]   req_sel1,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [n-1:0] resp_result,
  output logic         resp_zero,
  output logic         resp_err,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [n-1:0] alu_result,
  input  logic         alu_zero,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state;
  logic   rr_ptr;
  logic   win1;
  logic   accept;
  logic   sel_legal;

  // Winner selection and the ready decode, which is only live while IDLE
  always_comb begin
    win1       = req_valid1 & (~req_valid0 | rr_ptr);
    accept     = (state == IDLE) & (req_valid0 | req_valid1);
    req_ready0 = (state == IDLE) & req_valid0 & ~win1;
    req_ready1 = (state == IDLE) & win1;
    sel_legal  = (alu_sel == 4'b0000) || (alu_sel == 4'b0001) ||
                 (alu_sel == 4'b0010) || (alu_sel == 4'b0110);
  end

  // Control FSM with registered ALU operands and registered response fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      busy        <= 1'b0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a   <= win1 ? req_a1 : req_a0;
            alu_b   <= win1 ? req_b1 : req_b0;
            alu_sel <= win1 ? req_sel1 : req_sel0;
            resp_id <= win1;
            rr_ptr  <= ~win1;
            state   <= EXEC;
            busy    <= 1'b1;
          end
        end
        EXEC: begin
          resp_result <= alu_result;
          resp_zero   <= alu_zero;
          resp_err    <= ~sel_legal;
          resp_valid  <= 1'b1;
          state       <= RESP;
          busy        <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed test of the ALU share arbiter.
// A small behavioural ALU closes the loop on the alu_* ports.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req_valid0, req_ready0;
  logic [31:0] req_a0, req_b0;
  logic [3:0]  req_sel0;
  logic        req_valid1, req_ready1;
  logic [31:0] req_a1, req_b1;
  logic [3:0]  req_sel1;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_result;
  logic        resp_zero, resp_err;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_sel;
  logic        alu_zero;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_share_arbiter #(.n(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid0(req_valid0), .req_ready0(req_ready0),
    .req_a0(req_a0), .req_b0(req_b0), .req_sel0(req_sel0),
    .req_valid1(req_valid1), .req_ready1(req_ready1),
    .req_a1(req_a1), .req_b1(req_b1), .req_sel1(req_sel1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the external ALU
  always_comb begin
    alu_result = 32'h0;
    case (alu_sel)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] a0,
                               input logic [31:0] b0, input logic [3:0] s0,
                               input logic v1, input logic [31:0] a1,
                               input logic [31:0] b1, input logic [3:0] s1);
    req_valid0 = v0; req_a0 = a0; req_b0 = b0; req_sel0 = s0;
    req_valid1 = v1; req_a1 = a1; req_b1 = b1; req_sel1 = s1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One uncontested operation with resp_ready high; checks the full timeline
  task automatic runOp(input string tag, input logic port, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] sel,
                       input logic [31:0] expResult, input logic expZero,
                       input logic expErr);
    if (port) applyStimulus(0, 0, 0, 0, 1, a, b, sel);
    else      applyStimulus(1, a, b, sel, 0, 0, 0, 0);
    checkOutput({tag, "_ready"}, port ? req_ready1 : req_ready0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput({tag, "_exec_sel"}, alu_sel, sel);
    checkOutput({tag, "_exec_a"}, alu_a, a);
    tick();
    checkOutput({tag, "_valid"}, resp_valid, 1);
    checkOutput({tag, "_id"}, resp_id, port);
    checkOutput({tag, "_result"}, resp_result, expResult);
    checkOutput({tag, "_zero"}, resp_zero, expZero);
    checkOutput({tag, "_err"}, resp_err, expErr);
    tick();
    checkOutput({tag, "_idle_valid"}, resp_valid, 0);
    checkOutput({tag, "_idle_busy"}, busy, 0);
  endtask

  // Directed sequence
  initial begin
    logic expId;
    rst_n = 1'b0;
    resp_ready = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("rst_valid", resp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_sel", alu_sel, 0);
    checkOutput("rst_result", resp_result, 0);
    checkOutput("rst_ready0", req_ready0, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] single op");
    runOp("single_add", 0, 32'd5, 32'd7, 4'b0010, 32'd12, 0, 0);

    $display("[TB] contention");
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 32'd1, 32'd2, 4'b0010, 1, 32'd10, 32'd20, 4'b0001);
    for (int g = 0; g < 4; g++) begin
      expId = g[0];
      checkOutput("cont_ready0", req_ready0, !expId);
      checkOutput("cont_ready1", req_ready1, expId);
      tick();
      checkOutput("cont_exec_ready0", req_ready0, 0);
      checkOutput("cont_exec_ready1", req_ready1, 0);
      checkOutput("cont_alu_a", alu_a, expId ? 32'd10 : 32'd1);
      tick();
      checkOutput("cont_id", resp_id, expId);
      checkOutput("cont_result", resp_result, expId ? 32'd30 : 32'd3);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] subtract");
    runOp("sub_zero", 1, 32'd3, 32'd3, 4'b0110, 32'd0, 1, 0);
    runOp("sub_wrap", 1, 32'd0, 32'd1, 4'b0110, 32'hFFFF_FFFF, 0, 0);

    $display("[TB] back-pressure");
    resp_ready = 1'b0;
    applyStimulus(1, 32'd100, 32'd23, 4'b0010, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 32'hF0F0, 32'hFF00, 4'b0000, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_valid", resp_valid, 1);
      checkOutput("bp_result", resp_result, 32'd123);
      checkOutput("bp_id", resp_id, 0);
      checkOutput("bp_ready0", req_ready0, 0);
      checkOutput("bp_busy", busy, 1);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    checkOutput("bp_ready0_hs", req_ready0, 0);
    tick();
    checkOutput("bp_released", resp_valid, 0);
    checkOutput("bp_next_ready0", req_ready0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("bp_next_alu_a", alu_a, 32'hF0F0);
    tick();
    checkOutput("bp_next_result", resp_result, 32'hF000);
    tick();

    $display("[TB] illegal op");
    runOp("illegal", 0, 32'd9, 32'd4, 4'b0111, 32'd0, 1, 1);

    $display("[TB] reset mid-op");
    applyStimulus(1, 32'd50, 32'd1, 4'b0010, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_alu_a", alu_a, 0);
    checkOutput("mid_alu_sel", alu_sel, 0);
    tick();
    checkOutput("mid_no_resp", resp_valid, 0);
    rst_n = 1'b1;
    applyStimulus(1, 32'd4, 32'd4, 4'b0010, 1, 32'd6, 32'd6, 4'b0010);
    checkOutput("post_rst_ready0", req_ready0, 1);
    checkOutput("post_rst_ready1", req_ready1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_alu_a", alu_a, 32'd4);
    tick();
    checkOutput("post_rst_result", resp_result, 32'd8);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
